daq_capture_ctrl: RTL and testbench

- Sequencer for the DAQ acquisition path.
- Brings up the ADC in order: PL-DDR3 calibration, ADC power-up, then JESD204 link/SYSREF alignment.
- Arms on software request, starts a fixed-length capture on an external trigger edge, and gates ADC beats into the DMA/DDR3 write path.
- Sits between the PS GPIO/control registers, the JESD204 receive core, the ADC power-down pin and the capture DMA.

---
 rtl/daq_capture_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_daq_capture_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_capture_ctrl.sv
// DAQ acquisition sequencer: DDR3 calibration, ADC power-up, JESD204 link/SYSREF alignment, then triggered fixed-length capture.
// Optional link-wait timeout is built only when DAQ_CTRL_TIMEOUT_EN is defined.
module daq_capture_ctrl #(
  parameter int unsigned CNT_WIDTH      = 32,
  parameter logic [15:0] PWRUP_CYCLES   = 16'd1000,
  parameter logic [7:0]  SYNC_STABLE    = 8'd64,
  parameter logic [3:0]  SYSREF_MIN     = 4'd2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 arm,
  input  logic [CNT_WIDTH-1:0] capture_len,
  input  logic                 ddr3_calib_done,
  input  logic                 ddr3_error,
  input  logic                 rx_sync,
  input  logic                 rx_sysref,
  input  logic                 trig,
  input  logic                 adc_valid,
  input  logic                 dma_ready,
  output logic                 adc_pd,
  output logic                 capture_en,
  output logic                 capture_done,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic [2:0]           state,
  output logic                 error,
  output logic [1:0]           status_led
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PWRUP   = 3'd1,
    S_LINK    = 3'd2,
    S_READY   = 3'd3,
    S_ARMED   = 3'd4,
    S_CAPTURE = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            pwr_cnt_q, pwr_cnt_d;
  logic [7:0]             stable_q, stable_d;
  logic [3:0]             edge_cnt_q, edge_cnt_d;
  logic                   sysref_prev_q, trig_prev_q;
  logic [CNT_WIDTH-1:0]   len_q, len_d;
  logic [CNT_WIDTH-1:0]   beat_q, beat_d;
  logic [CNT_WIDTH-1:0]   beat_inc_s;
  logic                   sysref_rise_s, trig_rise_s, sync_ok_s;
  logic                   pwr_done_s, link_ready_s;
  logic                   accept_s, overflow_s, last_beat_s, link_lost_s;
  logic                   tmo_hit_s;

  assign sysref_rise_s = rx_sysref & ~sysref_prev_q;
  assign trig_rise_s   = trig & ~trig_prev_q;
  assign sync_ok_s     = rx_sync && (stable_q >= SYNC_STABLE);
  assign pwr_done_s    = ({1'b0, pwr_cnt_q} + 17'd1) >= {1'b0, PWRUP_CYCLES};
  assign link_ready_s  = sync_ok_s && sysref_rise_s &&
                         (({1'b0, edge_cnt_q} + 5'd1) >= {1'b0, SYSREF_MIN});
  assign accept_s      = adc_valid && dma_ready;
  assign overflow_s    = adc_valid && !dma_ready;
  assign beat_inc_s    = (beat_q == {CNT_WIDTH{1'b1}}) ? beat_q
                                                       : beat_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  assign last_beat_s   = accept_s && (beat_inc_s == len_q);
  assign link_lost_s   = !rx_sync &&
                         ((state_q == S_READY) || (state_q == S_ARMED) || (state_q == S_CAPTURE));

`ifdef DAQ_CTRL_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  assign tmo_hit_s = (state_q == S_LINK) && ((tmo_q + 32'd1) >= TIMEOUT_CYCLES);
  assign tmo_d     = (state_q != S_LINK)     ? 32'd0 :
                     (tmo_q == 32'hFFFF_FFFF) ? tmo_q : tmo_q + 32'd1;

  // Link-wait timeout counter, cleared whenever the FSM is outside LINK.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_q <= 32'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout_s;

  assign tmo_hit_s        = 1'b0;
  assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

  // Bring-up counters only run in their own state and restart on every entry.
  always_comb begin
    pwr_cnt_d  = 16'd0;
    stable_d   = 8'd0;
    edge_cnt_d = 4'd0;
    if (state_q == S_PWRUP) begin
      pwr_cnt_d = (pwr_cnt_q == 16'hFFFF) ? pwr_cnt_q : pwr_cnt_q + 16'd1;
    end else begin
      pwr_cnt_d = 16'd0;
    end
    if ((state_q == S_LINK) && rx_sync) begin
      stable_d   = (stable_q >= SYNC_STABLE) ? stable_q : stable_q + 8'd1;
      edge_cnt_d = edge_cnt_q;
      if (sync_ok_s && sysref_rise_s && (edge_cnt_q != 4'hF)) begin
        edge_cnt_d = edge_cnt_q + 4'd1;
      end else begin
        edge_cnt_d = edge_cnt_q;
      end
    end else begin
      stable_d   = 8'd0;
      edge_cnt_d = 4'd0;
    end
  end

  // Next-state logic; global overrides are checked before the per-state transitions.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else if (ddr3_error && (state_q != S_IDLE)) begin
      state_d = S_ERROR;
    end else if (link_lost_s) begin
      state_d = S_ERROR;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ddr3_calib_done) state_d = S_PWRUP;
          else                 state_d = S_IDLE;
        end
        S_PWRUP: begin
          if (pwr_done_s) state_d = S_LINK;
          else            state_d = S_PWRUP;
        end
        S_LINK: begin
          if (link_ready_s)   state_d = S_READY;
          else if (tmo_hit_s) state_d = S_ERROR;
          else                state_d = S_LINK;
        end
        S_READY: begin
          if (arm && (capture_len != {CNT_WIDTH{1'b0}})) begin
            state_d = S_ARMED;
            len_d   = capture_len;
            beat_d  = {CNT_WIDTH{1'b0}};
          end else begin
            state_d = S_READY;
          end
        end
        S_ARMED: begin
          if (trig_rise_s) state_d = S_CAPTURE;
          else             state_d = S_ARMED;
        end
        S_CAPTURE: begin
          if (overflow_s) begin
            state_d = S_ERROR;
          end else if (accept_s) begin
            beat_d  = beat_inc_s;
            state_d = last_beat_s ? S_DONE : S_CAPTURE;
          end else begin
            state_d = S_CAPTURE;
          end
        end
        S_DONE:  state_d = S_READY;
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      pwr_cnt_q     <= 16'd0;
      stable_q      <= 8'd0;
      edge_cnt_q    <= 4'd0;
      sysref_prev_q <= 1'b0;
      trig_prev_q   <= 1'b0;
      len_q         <= {CNT_WIDTH{1'b0}};
      beat_q        <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      pwr_cnt_q     <= pwr_cnt_d;
      stable_q      <= stable_d;
      edge_cnt_q    <= edge_cnt_d;
      sysref_prev_q <= rx_sysref;
      trig_prev_q   <= trig;
      len_q         <= len_d;
      beat_q        <= beat_d;
    end
  end

  // Outputs decode straight from the state register so they drop with it on reset.
  assign adc_pd       = (state_q == S_IDLE) || (state_q == S_ERROR);
  assign capture_en   = (state_q == S_CAPTURE);
  assign capture_done = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign beat_count   = beat_q;
  assign state        = state_q;
  assign status_led   = {(state_q == S_READY) || (state_q == S_ARMED) ||
                         (state_q == S_CAPTURE) || (state_q == S_DONE),
                         (state_q == S_ARMED) || (state_q == S_CAPTURE)};

endmodule

// File: tb/tb_daq_capture_ctrl.sv
// Self-checking bench for daq_capture_ctrl: table-driven captures with a result scoreboard plus
// hand-written sequences for bring-up timing, overflow, link loss, priority, reset and link timeout.
module tb_daq_capture_ctrl;

  logic        clk = 1'b0;
  logic        resetn, enable, arm, ddr3_calib_done, ddr3_error;
  logic        rx_sync, rx_sysref, trig, adc_valid, dma_ready;
  logic [31:0] capture_len;
  logic        adc_pd, capture_en, capture_done, error;
  logic [31:0] beat_count;
  logic [2:0]  state;
  logic [1:0]  status_led;

  int nchk  = 0;
  int nfail = 0;
  int cyc   = 0;

  typedef struct { int len; int gap; int en_exp; bit pre; } vec_t;
  typedef struct { int len; int en; } sb_t;
  vec_t tbl[6];
  sb_t  sbq[$];

  daq_capture_ctrl #(
    .CNT_WIDTH(32), .PWRUP_CYCLES(16'd1000), .SYNC_STABLE(8'd64),
    .SYSREF_MIN(4'd2), .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .arm(arm), .capture_len(capture_len),
    .ddr3_calib_done(ddr3_calib_done), .ddr3_error(ddr3_error), .rx_sync(rx_sync),
    .rx_sysref(rx_sysref), .trig(trig), .adc_valid(adc_valid), .dma_ready(dma_ready),
    .adc_pd(adc_pd), .capture_en(capture_en), .capture_done(capture_done),
    .beat_count(beat_count), .state(state), .error(error), .status_led(status_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: sample point is 1ns after the edge; SYSREF pulses every 32 cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rx_sysref = (cyc % 32 == 0);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    for (int n = 0; n < budget && state !== s; n++) tick();
    chk(nm, {29'd0, state}, {29'd0, s});
  endtask

  task automatic do_capture(input vec_t v);
    int  i;
    int  en;
    bit  got;
    sb_t exp;
    capture_len = v.len;
    trig = v.pre;
    arm  = 1'b1;
    sbq.push_back('{len: v.len, en: v.en_exp});
    tick();
    arm = 1'b0;
    chk("armed", {29'd0, state}, 32'd4);
    if (v.pre) begin
      tick();
      tick();
      chk("stale_trig_ignored", {29'd0, state}, 32'd4);
      trig = 1'b0;
      tick();
    end
    trig = 1'b1;
    tick();
    i = 0; en = 0; got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      if (capture_done) begin
        got = 1;
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          exp = sbq.pop_front();
          chk("cap_beats", beat_count, exp.len);
          chk("cap_en_cycles", en, exp.en);
        end
      end else begin
        en += capture_en ? 1 : 0;
        if (state == 3'd5) begin
          adc_valid = (i % (v.gap + 1) == 0);
          dma_ready = adc_valid ? 1'b1 : 1'($urandom_range(0, 1));
          i++;
        end else begin
          adc_valid = 1'b0;
        end
        tick();
      end
    end
    if (!got) chk("cap_done_timeout", 32'd0, 32'd1);
    adc_valid = 1'b0;
    dma_ready = 1'b1;
    trig      = 1'b0;
    tick();
    chk("back_ready", {29'd0, state}, 32'd3);
    chk("done_single", {31'd0, capture_done}, 32'd0);
  endtask

  task automatic arm_and_trigger(input int len);
    capture_len = len;
    arm = 1'b1;
    trig = 1'b0;
    tick();
    arm = 1'b0;
    trig = 1'b1;
    tick();
    chk("in_capture", {29'd0, state}, 32'd5);
  endtask

  initial begin
    int k, l, exp_ready, nedge;
    tbl[0] = '{len: 8, gap: 0, en_exp: 8,  pre: 1'b0};
    tbl[1] = '{len: 1, gap: 0, en_exp: 1,  pre: 1'b0};
    tbl[2] = '{len: 3, gap: 1, en_exp: 5,  pre: 1'b0};
    tbl[3] = '{len: 5, gap: 2, en_exp: 13, pre: 1'b0};
    tbl[4] = '{len: 2, gap: 3, en_exp: 5,  pre: 1'b0};
    tbl[5] = '{len: 4, gap: 0, en_exp: 4,  pre: 1'b1};

    resetn = 1'b0; enable = 1'b0; arm = 1'b0; capture_len = 32'd0;
    ddr3_calib_done = 1'b0; ddr3_error = 1'b0; rx_sync = 1'b0; rx_sysref = 1'b0;
    trig = 1'b0; adc_valid = 1'b0; dma_ready = 1'b1;
    repeat (3) tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_adc_pd", {31'd0, adc_pd}, 32'd1);
    chk("rst_capture_en", {31'd0, capture_en}, 32'd0);
    chk("rst_done", {31'd0, capture_done}, 32'd0);
    chk("rst_beats", beat_count, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_led", {30'd0, status_led}, 32'd0);

    // Bring-up with exact timing.
    resetn = 1'b1; enable = 1'b1; rx_sync = 1'b1;
    tick(); tick();
    chk("idle_wait_calib", {29'd0, state}, 32'd0);
    ddr3_calib_done = 1'b1;
    k = cyc;
    chk("pd_before_calib", {31'd0, adc_pd}, 32'd1);
    tick();
    chk("pd_after_calib", {31'd0, adc_pd}, 32'd0);
    chk("pwrup_state", {29'd0, state}, 32'd1);
    wait_state(3'd2, 2000, "reach_link");
    l = cyc;
    chk("link_entry_cycle", l, k + 1 + 1000);
    nedge = 0; exp_ready = 0;
    for (int c = l + 64; c < l + 400 && exp_ready == 0; c++) begin
      if (c % 32 == 0) nedge++;
      if (nedge == 2) exp_ready = c + 1;
    end
    wait_state(3'd3, 500, "reach_ready");
    chk("ready_cycle", cyc, exp_ready);
    chk("ready_led", {30'd0, status_led}, 32'd2);

    // Table-driven captures.
    foreach (tbl[j]) do_capture(tbl[j]);

    // Zero-length arm is ignored.
    capture_len = 32'd0; arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    chk("arm_len0", {29'd0, state}, 32'd3);

    // Overflow on the fourth beat.
    arm_and_trigger(8);
    adc_valid = 1'b1; dma_ready = 1'b1;
    repeat (3) tick();
    dma_ready = 1'b0;
    tick();
    chk("ovf_state", {29'd0, state}, 32'd7);
    chk("ovf_error", {31'd0, error}, 32'd1);
    chk("ovf_adc_pd", {31'd0, adc_pd}, 32'd1);
    chk("ovf_capture_en", {31'd0, capture_en}, 32'd0);
    chk("ovf_beats", beat_count, 32'd3);
    adc_valid = 1'b0; dma_ready = 1'b1;
    tick();
    chk("err_sticky", {29'd0, state}, 32'd7);
    enable = 1'b0;
    tick();
    chk("err_clear_state", {29'd0, state}, 32'd0);
    chk("err_clear_flag", {31'd0, error}, 32'd0);
    chk("beats_hold", beat_count, 32'd3);
    enable = 1'b1;
    wait_state(3'd3, 2000, "rebringup1");

    // Link loss in ARMED, then ddr3_error together with enable low.
    capture_len = 32'd4; arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("ll_armed", {29'd0, state}, 32'd4);
    chk("armed_led", {30'd0, status_led}, 32'd3);
    rx_sync = 1'b0;
    tick();
    rx_sync = 1'b1;
    chk("link_loss", {29'd0, state}, 32'd7);
    ddr3_error = 1'b1; enable = 1'b0;
    tick();
    chk("prio_enable", {29'd0, state}, 32'd0);
    ddr3_error = 1'b0; enable = 1'b1;
    wait_state(3'd3, 2000, "rebringup2");
    ddr3_error = 1'b1;
    tick();
    ddr3_error = 1'b0;
    chk("ddr3_err", {29'd0, state}, 32'd7);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    wait_state(3'd3, 2000, "rebringup3");

    // Reset mid-capture.
    arm_and_trigger(8);
    adc_valid = 1'b1;
    tick(); tick();
    resetn = 1'b0;
    #1;
    chk("mrst_state", {29'd0, state}, 32'd0);
    chk("mrst_adc_pd", {31'd0, adc_pd}, 32'd1);
    chk("mrst_capture_en", {31'd0, capture_en}, 32'd0);
    chk("mrst_beats", beat_count, 32'd0);
    chk("mrst_led", {30'd0, status_led}, 32'd0);
    adc_valid = 1'b0;
    repeat (3) begin
      tick();
      chk("mrst_no_done", {31'd0, capture_done}, 32'd0);
    end

    // Link never comes up.
    rx_sync = 1'b0;
    resetn  = 1'b1;
    wait_state(3'd2, 2000, "tmo_link");
`ifdef DAQ_CTRL_TIMEOUT_EN
    repeat (99) tick();
    chk("tmo_not_yet", {29'd0, state}, 32'd2);
    tick();
    chk("tmo_error", {29'd0, state}, 32'd7);
`else
    repeat (10000) tick();
    chk("no_tmo_link", {29'd0, state}, 32'd2);
`endif

    chk("sb_empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
